// File: rtl/sinc_down_timer_pkg.sv
// Shared definitions for the down-counting timer: state encoding and default widths.
package sinc_timer_pkg;

    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_PRE_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

endpackage

// File: rtl/sinc_down_timer_if.sv
// Control/status bundle of the down timer; master drives controls, slave is the timer.
interface sinc_down_timer_if #(
    parameter int unsigned WIDTH     = sinc_timer_pkg::DEF_WIDTH,
    parameter int unsigned PRE_WIDTH = sinc_timer_pkg::DEF_PRE_WIDTH
);
    logic                 load;
    logic [WIDTH-1:0]     load_value;
    logic                 start;
    logic                 enable;
    logic                 auto_reload;
    logic [PRE_WIDTH-1:0] prescale;
    logic [WIDTH-1:0]     count;
    logic                 busy;
    logic                 done;
    logic                 expired;

    modport master (
        output load, load_value, start, enable, auto_reload, prescale,
        input  count, busy, done, expired
    );

    modport slave (
        input  load, load_value, start, enable, auto_reload, prescale,
        output count, busy, done, expired
    );
endinterface

// File: rtl/sinc_down_timer_prescaler.sv
// Prescaler: produces one tick every prescale+1 enabled cycles; clear and reset zero it.
module sinc_prescaler #(
    parameter int unsigned PRE_WIDTH = sinc_timer_pkg::DEF_PRE_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [PRE_WIDTH-1:0] prescale,
    output logic                 tick
);
    logic [PRE_WIDTH-1:0] cnt_q, cnt_d;

    // >= rather than == so a shrunk prescale wraps at once instead of running to overflow
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q >= prescale) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + PRE_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/sinc_down_timer.sv
// Loadable down-counter/timer with prescaler, one-shot or auto-reload expiry.
module sinc_down_timer
    import sinc_timer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned PRE_WIDTH = DEF_PRE_WIDTH
) (
    input logic              clk,
    input logic              reset,
    sinc_down_timer_if.slave bus
);
    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             expired_q, expired_d;

    logic             tick;
    logic             pre_enable;
    logic [WIDTH-1:0] reload_src;

    assign pre_enable = bus.enable && (state_q == RUN);
    // A load coinciding with start or reload supplies the value directly
    assign reload_src = bus.load ? bus.load_value : reload_q;

    sinc_prescaler #(.PRE_WIDTH(PRE_WIDTH)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (pre_enable),
        .clear    (bus.start),
        .prescale (bus.prescale),
        .tick     (tick)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        reload_d  = reload_q;
        done_d    = 1'b0;
        expired_d = expired_q;

        if (bus.load) reload_d = bus.load_value;

        if (bus.start) begin
            expired_d = 1'b0;
            if (reload_src == '0) begin
                count_d   = '0;
                done_d    = 1'b1;
                expired_d = 1'b1;
                state_d   = EXPIRED;
            end else begin
                count_d = reload_src;
                state_d = RUN;
            end
        end else begin
            unique case (state_q)
                IDLE, EXPIRED: begin
                    if (bus.load) begin
                        count_d   = bus.load_value;
                        expired_d = 1'b0;
                        state_d   = IDLE;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (count_q > WIDTH'(1)) begin
                            count_d = count_q - WIDTH'(1);
                        end else begin
                            done_d = 1'b1;
                            // A zero reload cannot sustain a period, so it expires instead
                            if (bus.auto_reload && (reload_src != '0)) begin
                                count_d = reload_src;
                            end else begin
                                count_d   = '0;
                                expired_d = 1'b1;
                                state_d   = EXPIRED;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.expired = expired_q;
endmodule

// File: doc/sinc_down_timer.md
# sinc_down_timer

Synchronous, loadable down-counter/timer: the counterpart of the up-counter. It consumes a programmed count and runs it down to zero instead of accumulating one. It sits beside the up-counter in the timing datapath. Loads a reload value, counts down on prescaled ticks while enabled, and reports expiry as a one-cycle `done` pulse plus a sticky `expired` flag. Optional auto-reload makes it a periodic tick source.

## Interface
- `WIDTH`, 8: count and reload register width.
- `PRE_WIDTH`, 4: prescaler width. One tick every `prescale+1` enabled cycles.

- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `load` in 1: capture `load_value` into the reload register.
- `load_value` in WIDTH: value to load.
- `start` in 1: begin or restart countdown from the reload register.
- `enable` in 1: 1 = prescaler and count advance; 0 = everything holds (pause).
- `auto_reload` in 1: 1 = on expiry reload and keep running.
- `prescale` in PRE_WIDTH: tick divisor minus one. Sampled every cycle.
- `count` out WIDTH: current count value.
- `busy` out 1: 1 while in RUN.
- `done` out 1: one-cycle pulse, registered, on each expiry.
- `expired` out 1: sticky. Set on non-reload expiry; cleared by `load`, `start` or `reset`.

## Operation
- States:
  - IDLE: reset state.
  - RUN.
  - EXPIRED.
- Reset:
  - state IDLE.
  - `count`, reload register, prescaler = 0.
  - `busy`, `done`, `expired` = 0.
  - Reset has priority over every other input.
- `load`:
  - Always writes the reload register.
  - In IDLE or EXPIRED it also sets `count <= load_value` and clears `expired`.
  - In RUN, `count` is unaffected. The new value applies at the next reload or restart.
- `start` in any state:
  - `count <=` reload value, prescaler cleared, `expired` cleared.
  - If `load` is in the same cycle, the reload value is `load_value`.
  - If the reload value is 0: `done` pulses on the next edge, state goes to EXPIRED, `expired` = 1, and RUN is never entered.
  - Otherwise the state goes to RUN.
  - `start` in RUN is a restart.
- RUN:
  - When `enable` = 1, the prescaler increments. At `prescale` it wraps to 0 and generates a tick.
  - On a tick with `count > 1`: `count <= count - 1`.
  - On a tick with `count == 1`:
    - `done <= 1`.
    - If `auto_reload`: `count <=` reload value and stay in RUN.
    - Else: `count <= 0`, state goes to EXPIRED, `expired <= 1`, `busy <= 0`.
  - When `enable` = 0, the prescaler and `count` hold. A pending tick is not lost.
- EXPIRED: holds `count` = 0 until `load` or `start`. `enable` has no effect there.
- `done` is 0 in every cycle other than the expiry cycle.
- `count` never wraps below 0.
- Simultaneous `start` and tick: `start` wins. No `done`, count restarts.
- `prescale` changed mid-run: takes effect immediately. If the prescaler is already greater than the new `prescale`, it ticks on the next enabled cycle and wraps.

## Timing
- `start` sampled at edge N (`prescale` = 0, `enable` = 1, reload R > 0):
  - After edge N: `busy` = 1, `count` = R.
  - After edge N+R: `count` = 0 and `done` = 1 (same cycle).
- General expiry latency: R·(`prescale`+1) enabled cycles after `start`.
- Auto-reload period: exactly R·(`prescale`+1) enabled cycles between `done` pulses.
- All outputs are registered. No combinational input-to-output paths.

## Structure
- Shared package `sinc_timer_pkg`: state encoding constants (IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2) and default widths.
- Sub-module `sinc_prescaler`: PRE_WIDTH counter with `enable`, `clear` and `prescale` inputs and a `tick` output. Reset and clear zero it.
- Top level contains the FSM, the reload register and the count register.

## Test plan
- Load 3, start, `prescale` 0, `enable` 1 → `count` 3,2,1,0 on consecutive cycles; `done` = 1 exactly on the 0 cycle; `expired` = 1; `busy` = 0 afterward.
- Load 4, `prescale` 2, `auto_reload` 1 → `done` pulses every 12 cycles, count sequence 4,3,2,1,4,…, `busy` stays 1.
- Load 5, start, deassert `enable` for 7 cycles mid-count → `count` and prescaler frozen; expiry delayed by exactly 7 cycles.
- Load 0, start → `done` pulse 1 cycle later, EXPIRED, `busy` never 1.
- Load 6, start, assert `reset` at `count` = 3 → next cycle all outputs 0, state IDLE. `start` without `load` → immediate expiry, since the reload value is 0.
- Load 2 while running from 9, then `auto_reload` expiry → next period starts at 2. `start` asserted on a tick cycle → no `done`, count restarts at the reload value.
